// File: rtl/bsg_cache_nb_pkt_encode.sv
// Request-side packet encoder for the non-blocking cache.
// Ports: v_i/ready_o request in, v_o/ready_i packet out, error_o, sweep_done_o.
//
// Request attributes (kind, size, unsigned, mask enable, amo subop) are
// packed into one bsg_cache_nb opcode. Maintenance sweeps (tag init and
// tag flush) are expanded into one packet per (set, way), with the way as
// the inner loop. Every packet passes through a one-entry registered slot.
// An illegal request is accepted but produces no packet. error_o pulses on
// the following cycle. sweep_done_o pulses on the handshake of the last
// sweep packet.

module bsg_cache_nb_pkt_encode #(
  parameter int addr_width_p          = 32,
  parameter int data_width_p          = 64,
  parameter int sets_p                = 64,
  parameter int ways_p                = 8,
  parameter int block_size_in_words_p = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic                        v_i,
  output logic                        ready_o,
  input  logic [2:0]                  kind_i,
  input  logic [1:0]                  size_i,
  input  logic                        unsigned_i,
  input  logic                        mask_en_i,
  input  logic [3:0]                  amo_subop_i,
  input  logic [addr_width_p-1:0]     addr_i,
  input  logic [data_width_p-1:0]     data_i,
  input  logic [data_width_p/8-1:0]   mask_i,

  output logic                        v_o,
  input  logic                        ready_i,
  output logic [5:0]                  opcode_o,
  output logic [addr_width_p-1:0]     addr_o,
  output logic [data_width_p-1:0]     data_o,
  output logic [data_width_p/8-1:0]   mask_o,

  output logic                        error_o,
  output logic                        sweep_done_o
);

  localparam int mask_w_lp  = data_width_p / 8;
  localparam int lg_sets_lp = $clog2(sets_p);
  localparam int lg_ways_lp = $clog2(ways_p);
  localparam int boff_lp    = $clog2(block_size_in_words_p)
                            + $clog2(mask_w_lp);
  localparam int way_sh_lp  = lg_sets_lp + boff_lp;
  localparam bit dw64_lp    = (data_width_p == 64);

  // request kinds
  localparam logic [2:0] k_load_lp  = 3'd0;
  localparam logic [2:0] k_store_lp = 3'd1;
  localparam logic [2:0] k_amo_lp   = 3'd2;
  localparam logic [2:0] k_tagst_lp = 3'd3;
  localparam logic [2:0] k_tagfl_lp = 3'd4;

  // bsg_cache_nb_opcode_e values
  localparam logic [5:0] op_lb_lp    = 6'b000000;
  localparam logic [5:0] op_lh_lp    = 6'b000001;
  localparam logic [5:0] op_lw_lp    = 6'b000010;
  localparam logic [5:0] op_ld_lp    = 6'b000011;
  localparam logic [5:0] op_lbu_lp   = 6'b000100;
  localparam logic [5:0] op_lhu_lp   = 6'b000101;
  localparam logic [5:0] op_lwu_lp   = 6'b000110;
  localparam logic [5:0] op_ldu_lp   = 6'b000111;
  localparam logic [5:0] op_sb_lp    = 6'b001000;
  localparam logic [5:0] op_sh_lp    = 6'b001001;
  localparam logic [5:0] op_sw_lp    = 6'b001010;
  localparam logic [5:0] op_sd_lp    = 6'b001011;
  localparam logic [5:0] op_lm_lp    = 6'b001100;
  localparam logic [5:0] op_sm_lp    = 6'b001101;
  localparam logic [5:0] op_tagst_lp = 6'b010000;
  localparam logic [5:0] op_tagfl_lp = 6'b010001;

  // largest legal bsg_cache_amo_subop_e (maxu)
  localparam logic [3:0] amo_max_lp  = 4'd8;

  // FSM states
  localparam logic [0:0] idle_s  = 1'b0;
  localparam logic [0:0] sweep_s = 1'b1;

  // state
  logic [0:0]              state_q, state_d;
  logic                    flush_q, flush_d;
  logic                    last_q, last_d;
  logic [lg_sets_lp-1:0]   set_q, set_d;
  logic [lg_ways_lp-1:0]   way_q, way_d;

  logic                    v_q, v_d;
  logic [5:0]              op_q, op_d;
  logic [addr_width_p-1:0] addr_q, addr_d;
  logic [data_width_p-1:0] data_q, data_d;
  logic [mask_w_lp-1:0]    mask_q, mask_d;
  logic                    err_q, err_d;

  // request decode
  logic [5:0]              req_op;
  logic [mask_w_lp-1:0]    req_mask;
  logic                    req_illegal;
  logic                    req_sweep;

  always_comb begin
    req_op      = op_lb_lp;
    req_mask    = '1;
    req_illegal = 1'b0;
    req_sweep   = 1'b0;
    unique case (kind_i)
      k_load_lp: begin
        if (mask_en_i) begin
          req_op   = op_lm_lp;
          req_mask = mask_i;
        end else begin
          unique case (size_i)
            2'b00: req_op = unsigned_i ? op_lbu_lp : op_lb_lp;
            2'b01: req_op = unsigned_i ? op_lhu_lp : op_lh_lp;
            2'b10: req_op = unsigned_i ? op_lwu_lp : op_lw_lp;
            default: req_op = unsigned_i ? op_ldu_lp : op_ld_lp;
          endcase
        end
        req_illegal = (size_i == 2'b11) && !dw64_lp;
      end
      k_store_lp: begin
        if (mask_en_i) begin
          req_op   = op_sm_lp;
          req_mask = mask_i;
        end else begin
          unique case (size_i)
            2'b00: req_op = op_sb_lp;
            2'b01: req_op = op_sh_lp;
            2'b10: req_op = op_sw_lp;
            default: req_op = op_sd_lp;
          endcase
        end
        req_illegal = (size_i == 2'b11) && !dw64_lp;
      end
      k_amo_lp: begin
        // AMO opcodes are {1, is_double, subop}
        req_op      = {1'b1, size_i[0], amo_subop_i};
        req_illegal = !size_i[1]
                    || (amo_subop_i > amo_max_lp)
                    || ((size_i == 2'b11) && !dw64_lp);
      end
      k_tagst_lp, k_tagfl_lp: begin
        req_sweep = 1'b1;
      end
      default: begin
        req_illegal = 1'b1;
      end
    endcase
  end

  // handshakes
  logic slot_free;
  logic in_hs;
  logic out_hs;
  logic sweep_ld;
  logic sweep_exit;
  logic ld_req;
  logic start_sweep;

  assign slot_free = !v_q || ready_i;
  assign out_hs    = v_q && ready_i;

  // last_q marks that the final sweep packet is already in the slot,
  // so its handshake is the sweep exit.
  assign sweep_exit = (state_q == sweep_s) && last_q && out_hs;
  assign sweep_ld   = (state_q == sweep_s) && !last_q && slot_free;

  assign ready_o = !reset_i
                && (((state_q == idle_s) && slot_free) || sweep_exit);

  assign in_hs       = v_i && ready_o;
  assign ld_req      = in_hs && !req_illegal && !req_sweep;
  assign start_sweep = in_hs && !req_illegal && req_sweep;

  logic [addr_width_p-1:0] sweep_addr;

  assign sweep_addr = (addr_width_p'(way_q) << way_sh_lp)
                    | (addr_width_p'(set_q) << boff_lp);

  always_comb begin
    v_d    = v_q;
    op_d   = op_q;
    addr_d = addr_q;
    data_d = data_q;
    mask_d = mask_q;
    err_d  = in_hs && req_illegal;

    if (ld_req) begin
      v_d    = 1'b1;
      op_d   = req_op;
      addr_d = addr_i;
      data_d = data_i;
      mask_d = req_mask;
    end else if (sweep_ld) begin
      v_d    = 1'b1;
      op_d   = flush_q ? op_tagfl_lp : op_tagst_lp;
      addr_d = sweep_addr;
      data_d = '0;
      mask_d = '0;
    end else if (out_hs) begin
      v_d    = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    last_d  = last_q;
    set_d   = set_q;
    way_d   = way_q;

    if (start_sweep) begin
      state_d = sweep_s;
      flush_d = (kind_i == k_tagfl_lp);
      last_d  = 1'b0;
      set_d   = '0;
      way_d   = '0;
    end else if (sweep_exit) begin
      state_d = idle_s;
      last_d  = 1'b0;
    end else if (sweep_ld) begin
      way_d = way_q + 1'b1;
      if (&way_q) begin
        set_d = set_q + 1'b1;
      end
      if ((&way_q) && (&set_q)) begin
        last_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= idle_s;
      flush_q <= 1'b0;
      last_q  <= 1'b0;
      set_q   <= '0;
      way_q   <= '0;
      v_q     <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      last_q  <= last_d;
      set_q   <= set_d;
      way_q   <= way_d;
      v_q     <= v_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  assign v_o          = v_q && !reset_i;
  assign opcode_o     = op_q;
  assign addr_o       = addr_q;
  assign data_o       = data_q;
  assign mask_o       = mask_q;
  assign error_o      = err_q && !reset_i;
  assign sweep_done_o = sweep_exit && !reset_i;

endmodule

// File: tb/tb_bsg_cache_nb_pkt_encode.sv
// Self-checking bench for bsg_cache_nb_pkt_encode.
// Directed steps plus random traffic against a packet-queue model.

module tb_bsg_cache_nb_pkt_encode;

  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int SETS = 4;
  localparam int WAYS = 2;
  localparam int BLK  = 8;
  localparam int BOFF = 6;
  localparam int MW   = DW / 8;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          v_i;
  logic          ready_o;
  logic [2:0]    kind_i;
  logic [1:0]    size_i;
  logic          unsigned_i;
  logic          mask_en_i;
  logic [3:0]    amo_subop_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] data_i;
  logic [MW-1:0] mask_i;
  logic          v_o;
  logic          ready_i;
  logic [5:0]    opcode_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] data_o;
  logic [MW-1:0] mask_o;
  logic          error_o;
  logic          sweep_done_o;

  bsg_cache_nb_pkt_encode #(
    .addr_width_p(AW),
    .data_width_p(DW),
    .sets_p(SETS),
    .ways_p(WAYS),
    .block_size_in_words_p(BLK)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .v_i(v_i),
    .ready_o(ready_o),
    .kind_i(kind_i),
    .size_i(size_i),
    .unsigned_i(unsigned_i),
    .mask_en_i(mask_en_i),
    .amo_subop_i(amo_subop_i),
    .addr_i(addr_i),
    .data_i(data_i),
    .mask_i(mask_i),
    .v_o(v_o),
    .ready_i(ready_i),
    .opcode_o(opcode_o),
    .addr_o(addr_o),
    .data_o(data_o),
    .mask_o(mask_o),
    .error_o(error_o),
    .sweep_done_o(sweep_done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]    op;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [MW-1:0] m;
    bit            last;
  } pkt_t;

  pkt_t q[$];
  bit   sweep_act;
  bit   err_pend;
  int   n_asrt;
  int   n_fail;
  int   npkt;
  int   ndone;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // opcode numbering of bsg_cache_nb_opcode_e
  function automatic logic [5:0] exp_op(input int k, input int sz,
                                        input bit u, input bit me,
                                        input int sub);
    int r;
    r = 0;
    if (k == 0) r = me ? 12 : (u ? 4 : 0) + sz;
    else if (k == 1) r = me ? 13 : 8 + sz;
    else if (k == 2) r = (sz == 3 ? 48 : 32) + sub;
    return 6'(r);
  endfunction

  function automatic bit is_illegal(input int k, input int sz,
                                    input int sub);
    if (k > 4) return 1;
    if (k < 3 && sz == 3 && DW == 32) return 1;
    if (k == 2 && (sz < 2 || sub > 8)) return 1;
    return 0;
  endfunction

  task automatic push_req();
    pkt_t p;
    int k;
    k = int'(kind_i);
    if (is_illegal(k, int'(size_i), int'(amo_subop_i))) return;
    if (k == 3 || k == 4) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          p.op   = (k == 3) ? 6'd16 : 6'd17;
          p.a    = AW'(w * (SETS << BOFF) + s * (1 << BOFF));
          p.d    = '0;
          p.m    = '0;
          p.last = (s == SETS - 1) && (w == WAYS - 1);
          q.push_back(p);
        end
      end
      sweep_act = 1;
    end else begin
      p.op   = exp_op(k, int'(size_i), unsigned_i, mask_en_i,
                      int'(amo_subop_i));
      p.a    = addr_i;
      p.d    = data_i;
      p.m    = (mask_en_i && k < 2) ? mask_i : '1;
      p.last = 0;
      q.push_back(p);
    end
  endtask

  // Checks one cycle just before the rising edge, then advances.
  task automatic tick();
    logic ohs, ihs, exp_rdy;
    pkt_t p;
    #1;
    ohs = v_o && ready_i;
    ihs = v_i && ready_o;
    if (sweep_act)
      exp_rdy = ohs && q.size() > 0 && q[0].last;
    else
      exp_rdy = !v_o || ready_i;
    chk("ready_o", ready_o, exp_rdy);
    chk("error_o", error_o, err_pend);
    if (q.size() == 0) chk("idle_v_o", v_o, 0);
    if (ohs && q.size() > 0) begin
      p = q.pop_front();
      chk("pkt_op", opcode_o, p.op);
      chk("pkt_addr", addr_o, p.a);
      chk("pkt_data", data_o, p.d);
      chk("pkt_mask", mask_o, p.m);
      chk("pkt_done", sweep_done_o, p.last);
      if (p.last) sweep_act = 0;
      npkt++;
    end else begin
      chk("no_done", sweep_done_o, 0);
    end
    if (sweep_done_o) ndone++;
    err_pend = 0;
    if (ihs) begin
      err_pend = is_illegal(int'(kind_i), int'(size_i),
                            int'(amo_subop_i));
      push_req();
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("rst_v_o", v_o, 0);
      chk("rst_ready_o", ready_o, 0);
      chk("rst_done", sweep_done_o, 0);
      chk("rst_error", error_o, 0);
      @(posedge clk);
      @(negedge clk);
    end
    reset_i   = 1'b0;
    q.delete();
    sweep_act = 0;
    err_pend  = 0;
  endtask

  task automatic set_req(input int k, input int sz, input bit u,
                         input bit me, input int sub,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] d,
                         input logic [MW-1:0] m);
    v_i         = 1'b1;
    kind_i      = 3'(k);
    size_i      = 2'(sz);
    unsigned_i  = u;
    mask_en_i   = me;
    amo_subop_i = 4'(sub);
    addr_i      = a;
    data_i      = d;
    mask_i      = m;
  endtask

  task automatic drain(input string tag, input int budget,
                       input bit rnd);
    int c;
    c = 0;
    while ((q.size() > 0 || v_o) && c < budget) begin
      ready_i = rnd ? 1'($urandom % 2) : 1'b1;
      tick();
      c++;
    end
    chk(tag, q.size(), 0);
  endtask

  initial begin
    n_asrt = 0; n_fail = 0; npkt = 0; ndone = 0;
    sweep_act = 0; err_pend = 0;
    reset_i = 1'b1; v_i = 1'b0; ready_i = 1'b1;
    kind_i = '0; size_i = '0; unsigned_i = 1'b0; mask_en_i = 1'b0;
    amo_subop_i = '0; addr_i = '0; data_i = '0; mask_i = '0;
    @(negedge clk);
    do_reset(3);
    #1;
    chk("rst_opcode", opcode_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_mask", mask_o, 0);

    // load word unsigned
    set_req(0, 2, 1, 0, 0, 32'h1000, 64'hdead_beef, 8'h00);
    tick();
    v_i = 1'b0;
    #1;
    chk("lwu_v_o", v_o, 1);
    chk("lwu_op", opcode_o, 6'b000110);
    chk("lwu_addr", addr_o, 32'h1000);
    chk("lwu_mask", mask_o, 8'hFF);
    tick();

    // amoadd.d then illegal amo
    set_req(2, 3, 0, 0, 1, 32'h2008, 64'd5, 8'h00);
    tick();
    v_i = 1'b0;
    #1;
    chk("amo_op", opcode_o, 6'b110001);
    chk("amo_data", data_o, 5);
    tick();
    set_req(2, 1, 0, 0, 1, 32'h2010, 64'd7, 8'h00);
    tick();
    v_i = 1'b0;
    #1;
    chk("ill_error", error_o, 1);
    chk("ill_v_o", v_o, 0);
    tick();
    #1;
    chk("ill_error_off", error_o, 0);
    set_req(0, 3, 0, 0, 0, 32'h3000, 64'h0, 8'h00);
    #1;
    chk("post_ill_ready", ready_o, 1);
    tick();
    v_i = 1'b0;
    #1;
    chk("post_ill_op", opcode_o, 6'b000011);
    tick();

    // backpressure, then back-to-back SB, SM
    ready_i = 1'b0;
    set_req(1, 3, 0, 0, 0, 32'h4000, 64'h1122_3344_5566_7788, 8'h00);
    tick();
    set_req(1, 0, 1, 0, 0, 32'h4001, 64'hAB, 8'h00);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_v_o", v_o, 1);
      chk("bp_op", opcode_o, 6'b001011);
      chk("bp_addr", addr_o, 32'h4000);
      chk("bp_data", data_o, 64'h1122_3344_5566_7788);
      tick();
    end
    ready_i = 1'b1;
    tick();
    set_req(1, 2, 0, 1, 0, 32'h4010, 64'h55, 8'h0F);
    #1;
    chk("b2b_sb_v", v_o, 1);
    chk("b2b_sb_op", opcode_o, 6'b001000);
    tick();
    v_i = 1'b0;
    #1;
    chk("b2b_sm_v", v_o, 1);
    chk("b2b_sm_op", opcode_o, 6'b001101);
    chk("b2b_sm_mask", mask_o, 8'h0F);
    tick();
    drain("drain_bp", 10, 0);

    // tag-init sweep
    npkt = 0; ndone = 0;
    set_req(3, 0, 0, 0, 0, 32'hFFFF, 64'h0, 8'hFF);
    tick();
    v_i = 1'b0;
    drain("tagst_timeout", 40, 0);
    chk("tagst_pkts", npkt, SETS * WAYS);
    chk("tagst_done", ndone, 1);

    // tag-flush sweep with random backpressure
    npkt = 0; ndone = 0;
    set_req(4, 0, 0, 0, 0, 32'h0, 64'h0, 8'h0);
    tick();
    v_i = 1'b0;
    drain("tagfl_timeout", 300, 1);
    chk("tagfl_pkts", npkt, SETS * WAYS);
    chk("tagfl_done", ndone, 1);

    // random mix of legal and illegal requests
    for (int i = 0; i < 120; i++) begin
      int k;
      k = int'($urandom % 6);
      if (k >= 3) k = k + 2;
      set_req(k, int'($urandom % 4), 1'($urandom), 1'($urandom),
              int'($urandom % 12), AW'($urandom),
              {$urandom, $urandom}, MW'($urandom));
      v_i     = 1'($urandom % 4 != 0);
      ready_i = 1'($urandom % 3 != 0);
      tick();
    end
    v_i = 1'b0;
    drain("rand_timeout", 20, 0);

    // reset in the middle of a sweep
    npkt = 0; ndone = 0;
    set_req(3, 0, 0, 0, 0, 32'h0, 64'h0, 8'h0);
    tick();
    v_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    do_reset(2);
    chk("midrst_done", ndone, 0);
    set_req(0, 2, 0, 0, 0, 32'h5000, 64'h9, 8'h0);
    #1;
    chk("midrst_ready", ready_o, 1);
    tick();
    v_i = 1'b0;
    #1;
    chk("midrst_ld_op", opcode_o, 6'b000010);
    tick();
    npkt = 0; ndone = 0;
    set_req(3, 0, 0, 0, 0, 32'h0, 64'h0, 8'h0);
    tick();
    v_i = 1'b0;
    drain("resweep_timeout", 40, 0);
    chk("resweep_pkts", npkt, SETS * WAYS);
    chk("resweep_done", ndone, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_cache_nb_pkt_encode.md
Name: bsg_cache_nb_pkt_encode

Overview:
- Request-side encoder for the non-blocking cache. Converts abstract core/DMA-side requests into bsg_cache_nb packets: opcode, addr, data and mask, with the opcode of type bsg_cache_nb_opcode_e.
- It is the inverse of the cache's opcode decode: every field the decoder extracts is taken here as a request attribute and packed into one opcode.
- It also sequences multi-packet maintenance sweeps (tag init, tag flush) over every set/way, so software and boot logic need not issue them one by one.
- Sits between the requester and the cache packet input, behind a one-entry registered output slot.

Parameters:
- addr_width_p, 32, packet address width.
- data_width_p, 64, data width; must be 32 or 64.
- sets_p, 64, cache sets; power of 2, ≥2.
- ways_p, 8, cache ways; power of 2, ≥2.
- block_size_in_words_p, 8, words per block; power of 2.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- v_i  in  1  request valid.
- ready_o  out  1  request accept (ready-and handshake).
- kind_i  in  3  0=load, 1=store, 2=amo, 3=tag-init sweep, 4=tag-flush sweep, 5–7 illegal.
- size_i  in  2  00=byte, 01=half, 10=word, 11=double.
- unsigned_i  in  1  load zero-extend.
- mask_en_i  in  1  masked load/store (LM/SM).
- amo_subop_i  in  4  bsg_cache_amo_subop_e.
- addr_i  in  addr_width_p  request address.
- data_i  in  data_width_p  store/amo data.
- mask_i  in  data_width_p/8  byte mask.
- v_o  out  1  packet valid.
- ready_i  in  1  cache accepts packet.
- opcode_o  out  6  bsg_cache_nb_opcode_e.
- addr_o  out  addr_width_p  packet address.
- data_o  out  data_width_p  packet data.
- mask_o  out  data_width_p/8  packet mask.
- error_o  out  1  one-cycle pulse on an illegal request.
- sweep_done_o  out  1  one-cycle pulse on the last sweep packet handshake.

Behaviour:
- **Reset:** v_o=0, error_o=0, sweep_done_o=0, ready_o=0 while reset_i=1. State returns to IDLE, set/way counters clear to 0, and opcode_o/addr_o/data_o/mask_o are 0. Reset mid-sweep abandons the sweep without a done pulse.
- **Handshake:** a transfer occurs when v_i&ready_o, or when v_o&ready_i. The output slot holds its contents stable while v_o&~ready_i.
- **States:** IDLE, SWEEP.
- **IDLE:**
  - ready_o = ~v_o | ready_i.
  - An accepted legal load/store/amo loads the slot; v_o=1 the next cycle (1-cycle latency, full throughput, no bubble on back-to-back transfers).
  - addr_o=addr_i, data_o=data_i. mask_o=mask_i for masked ops, else all ones.
- **Encoding:**
  - load & mask_en_i → LM. Else, by size: LB/LH/LW/LD if unsigned_i=0, LBU/LHU/LWU/LDU if unsigned_i=1.
  - store & mask_en_i → SM. Else, by size: SB/SH/SW/SD. unsigned_i is ignored for stores.
  - amo: size 10 → AMO<subop>_W; size 11 → AMO<subop>_D. Covers swap/add/xor/and/or/min/max/minu/maxu.
- **Illegal requests:** any of the following is illegal:
  - amo with size 0x;
  - size 11 with data_width_p=32;
  - kind 5–7;
  - amo_subop_i not in the 9 listed.
  
  An illegal request is accepted: the handshake completes, error_o pulses the next cycle, and no packet is produced.
- **Sweep start:** an accepted kind 3 or 4 enters SWEEP; ready_o=0 until exit. If the slot is still occupied, the first sweep packet loads when it drains.
- **SWEEP packets:** one packet per (set s, way w); way is the inner loop, set the outer.
  - addr_o = (w << (lg(sets_p)+boff)) | (s << boff), where boff = lg(block_size_in_words_p)+lg(data_width_p/8). Upper bits are 0.
  - data_o=0, mask_o=0.
  - opcode_o = TAGST for kind 3, TAGFL for kind 4.
- **SWEEP advance and exit:** the counters advance only on an output handshake. The handshake of packet (sets_p-1, ways_p-1) pulses sweep_done_o the same cycle and returns to IDLE; ready_o may assert that same cycle. Total packets = sets_p*ways_p.
- **Simultaneous events:** a slot drain and a new load in the same cycle are both honoured. error_o and sweep_done_o never assert together.

Test Plan:
- **Load encoding:** load size=10 unsigned=1, addr=0x1000 → one cycle later v_o=1, opcode_o=LWU, addr_o=0x1000, mask_o=0xFF.
- **AMO and illegal:** amo size=11 subop=add, data=5 → AMOADD_D, data_o=5. Then amo size=01 → error_o pulses once, v_o stays 0, next request accepted normally.
- **Backpressure:** ready_i low for 3 cycles with v_o=1 (SD) → outputs stable, ready_o=0. Release → back-to-back SB then SM (mask_i=0x0F, mask_o=0x0F) with no bubble.
- **Tag-init sweep** (sets_p=4, ways_p=2, data_width_p=64, block 8): kind=3 → 8 TAGST packets, addr order 0x000,0x100,0x040,0x140,0x080,0x180,0x0C0,0x1C0. sweep_done_o on the 8th handshake; ready_o=0 throughout.
- **Sweep with random ready_i:** kind=4 with ready_i randomly toggled → exactly sets_p*ways_p TAGFL packets, no duplicates or skips.
- **Reset mid-sweep:** reset_i asserted mid-sweep → v_o=0 and ready_o=0 during reset, no sweep_done_o. After reset, a load is accepted and the counters restart from (0,0).
